instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/core_pkg.sv | 35 +++
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core: sequencer state codes, fetch FSM states,
// the canonical NOP encoding and the PC advance rule.
package core_pkg;

    // addi x0, x0, 0 -- the instruction word presented whenever no real fetch is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Top-level sequencer states; FETCH and WRITE drive fetch_start / pc_update
    typedef enum logic [2:0] {
        CORE_FETCH   = 3'd0,
        CORE_DECODE  = 3'd1,
        CORE_EXECUTE = 3'd2,
        CORE_MEMORY  = 3'd3,
        CORE_WRITE   = 3'd4
    } core_state_t;

    // Instruction fetch unit states
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_DONE = 2'd3
    } fetch_state_t;

    // Next PC: an absolute branch target forced onto a word boundary, or the
    // sequential successor with natural 32-bit wrap
    function automatic logic [31:0] next_pc(
        input logic [31:0] cur_pc,
        input logic        taken,
        input logic [31:0] target
    );
        return taken ? {target[31:2], 2'b00} : cur_pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word read per fetch_start, waits for the
// instruction memory with a bounded timeout, and owns the program counter.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    output logic        fetch_done,
    output logic [31:0] instr_raw,
    output logic [31:0] pc,
    input  logic        pc_update,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [1:0]  fault
);

    // Counter only has to reach TIMEOUT-1 before the FSM leaves REQ/WAIT
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr_raw;
    logic [31:0]      r_imem_addr;
    logic [1:0]       r_fault;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic             w_start;
    logic             w_accept;
    logic             w_timeout;
    logic             w_tmo_hit;
    logic             w_misaligned;

    // fetch_start is only honoured from IDLE; anywhere else it is dropped
    assign w_start      = (r_state == FETCH_IDLE) && fetch_start;
    assign w_tmo_hit    = (r_tmo_cnt == TMO_LAST);
    assign w_misaligned = pc_update && branch_taken && (branch_target[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            // NOTE: sequential state always uses <= so every flop samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a response always wins over a timeout in the same cycle
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            FETCH_IDLE: begin
                if (fetch_start) begin
                    w_state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (imem_req_ready && imem_rsp_valid) begin
                    // Zero-latency memory: handshake and data in one cycle
                    w_accept     = 1'b1;
                    w_state_next = FETCH_DONE;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = FETCH_DONE;
                end else if (imem_req_ready) begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = FETCH_DONE;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = FETCH_DONE;
                end
            end
            FETCH_DONE: begin
                w_state_next = FETCH_IDLE;
            end
            default: begin
                w_state_next = FETCH_IDLE;
            end
        endcase
    end

    // Timeout counter: cleared on entry to REQ, counts every REQ/WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (w_start) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == FETCH_REQ) || (r_state == FETCH_WAIT)) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    // Request address is captured once so a PC change mid-fetch cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_imem_addr <= RESET_PC;
        end else if (w_start) begin
            r_imem_addr <= r_pc;
        end
    end

    // Instruction register: real data on a response, NOP on timeout, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_raw <= NOP_INSTR;
        end else if (w_accept) begin
            r_instr_raw <= imem_rsp_data;
        end else if (w_timeout) begin
            r_instr_raw <= NOP_INSTR;
        end
    end

    // Program counter advances on pc_update regardless of fetch state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (pc_update) begin
            r_pc <= next_pc(r_pc, branch_taken, branch_target);
        end
    end

    // Sticky fault flags; only reset clears them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault <= 2'b00;
        end else begin
            if (w_timeout) begin
                r_fault[0] <= 1'b1;
            end
            if (w_misaligned) begin
                r_fault[1] <= 1'b1;
            end
        end
    end

    // Handshake and completion strobes decode directly from the state register
    assign imem_req_valid = (r_state == FETCH_REQ);
    assign fetch_done     = (r_state == FETCH_DONE);
    assign imem_addr      = r_imem_addr;
    assign instr_raw      = r_instr_raw;
    assign pc             = r_pc;
    assign fault          = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a driver issues fetches against a scripted
// memory and pushes expectations; a negedge monitor pops and compares them.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 16;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic        fetch_done;
    logic [31:0] instr_raw;
    logic [31:0] pc;
    logic        pc_update;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [1:0]  fault;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] model_pc    = RST_PC;
    logic [1:0]  model_fault = 2'b00;
    exp_t        mon_e;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_start    (fetch_start),
        .fetch_done     (fetch_done),
        .instr_raw      (instr_raw),
        .pc             (pc),
        .pc_update      (pc_update),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle; apply the PC rule to whatever pc_update was sampled, then drop pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst && pc_update) begin
            if (branch_taken) begin
                model_pc = branch_target & ~32'h3;
                if (branch_target[1:0] != 2'b00) model_fault[1] = 1'b1;
            end else begin
                model_pc = model_pc + 32'd4;
            end
        end
        fetch_start    = 1'b0;
        pc_update      = 1'b0;
        branch_taken   = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    task automatic drive_upd();
        pc_update     = 1'b1;
        branch_taken  = ($urandom_range(0, 1) == 1);
        branch_target = $urandom();
        if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
    endtask

    // One fetch. Memory is ready on the rd+1-th request cycle and answers sd cycles later.
    // The fetch lasts min(answer cycle, TMO) cycles after fetch_start's cycle + 1.
    task automatic run_fetch(input int rd, input int sd, input logic [31:0] data,
                             input bit spam, input bit rupd);
        exp_t e;
        int   kh;
        int   kr;
        int   k_end;
        bit   to;
        kh    = rd + 1;
        kr    = kh + sd;
        to    = (kr > TMO);
        k_end = to ? TMO : kr;
        fetch_start = 1'b1;
        e.data      = to ? NOP : data;
        e.done_cyc  = cyc + 1 + k_end;
        exp_q.push_back(e);
        if (kh <= TMO) addr_q.push_back(model_pc);
        for (int k = 1; k <= k_end; k++) begin
            tick();
            imem_req_ready = (k == kh);
            imem_rsp_valid = (k == kr);
            imem_rsp_data  = (k == kr) ? data : $urandom();
            fetch_start    = spam;
            if (rupd && ($urandom_range(0, 4) == 0)) drive_upd();
        end
        tick();
        if (to) model_fault[0] = 1'b1;
        fetch_start    = spam;
        imem_rsp_valid = spam;
        imem_rsp_data  = $urandom();
        tick();
        check("done_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        addr_q.delete();
    endtask

    // Monitor: compares every handshake address and every fetch_done against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (imem_req_valid && imem_req_ready) begin
                if (addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_handshake: addr 0x%08h, no request expected", imem_addr);
                end else begin
                    check("imem_addr", imem_addr, addr_q.pop_front());
                end
            end
            if (fetch_done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: fetch_done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_raw", instr_raw, mon_e.data);
                    check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                    check("pc_at_done", pc, model_pc);
                    check("fault_at_done", 32'(fault), 32'(model_fault));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        fetch_start    = 1'b0;
        pc_update      = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetch_done", 32'(fetch_done), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_raw", instr_raw, NOP);
        check("rst_pc", pc, RST_PC);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b1;
        tick();

        // Minimum-latency fetch
        run_fetch(0, 0, 32'h0050_0093, 1'b0, 1'b0);

        // Misaligned branch target
        pc_update = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0102;
        tick();
        check("misaligned_pc", pc, 32'h0000_0100);
        check("misaligned_fault", 32'(fault), 32'd2);

        // Fetch at the top of the address space, then wrap
        pc_update = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        run_fetch(0, 1, $urandom(), 1'b0, 1'b0);
        pc_update = 1'b1; branch_taken = 1'b0;
        tick();
        check("wrap_pc", pc, 32'h0000_0000);

        // Memory never ready: timeout delivers NOP and sets fault[0]
        run_fetch(19, 0, $urandom(), 1'b0, 1'b0);
        check("timeout_fault", 32'(fault), 32'd3);
        check("timeout_instr", instr_raw, NOP);

        // Timeout boundaries: last-cycle response accepted, one later is not
        run_fetch(3, 12, $urandom(), 1'b0, 1'b0);
        run_fetch(3, 13, $urandom(), 1'b0, 1'b0);
        run_fetch(15, 0, $urandom(), 1'b0, 1'b0);
        run_fetch(15, 1, $urandom(), 1'b0, 1'b0);

        // Repeated fetch_start while busy yields exactly one fetch_done
        run_fetch(1, 3, $urandom(), 1'b1, 1'b0);
        run_fetch(0, 0, $urandom(), 1'b1, 1'b1);

        // Reset while waiting; stale response after release must be ignored
        fetch_start = 1'b1;
        addr_q.push_back(model_pc);
        tick();
        imem_req_ready = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        model_pc    = RST_PC;
        model_fault = 2'b00;
        exp_q.delete();
        addr_q.delete();
        #1;
        check("async_rst_instr", instr_raw, NOP);
        check("async_rst_pc", pc, RST_PC);
        check("async_rst_fault", 32'(fault), 32'd0);
        tick();
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b1;
        tick();
        tick();
        check("stale_rsp_instr", instr_raw, NOP);
        check("stale_rsp_done", 32'(fetch_done), 32'd0);

        // Randomized traffic with PC updates between and during fetches
        for (int t = 0; t < 40; t++) begin
            int rd;
            int sd;
            rd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            sd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 3));
            run_fetch(rd, sd, $urandom(), ($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                drive_upd();
                tick();
                check("pc_after_update", pc, model_pc);
                check("fault_after_update", 32'(fault), 32'(model_fault));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        check("final_queue", 32'(exp_q.size() + addr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
